// File: rtl/kt8_pc_sequencer.sv
// rtl/kt8_pc_sequencer.sv - KT8 program counter and instruction fetch sequencer
// Fetches one byte per instruction, samples decoder controls once in EXEC, then advances the PC.
module kt8_pc_sequencer #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [7:0]    mem_data_i,
    output logic [7:0]    instr_o,
    output logic          instr_valid_o,
    input  logic          jump_up_i,
    input  logic          jump_down_i,
    input  logic [3:0]    jump_distance_i,
    input  logic          rst_req_i,
    input  logic          hlt_i,
    input  logic          ex_stall_i,
    input  logic          run_i,
    output logic [AW-1:0] pc_o,
    output logic          halted_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    instr_q, instr_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          halted_q, halted_d;
    logic          err_q, err_d;

    logic [AW-1:0] dist_ext;
    logic [AW-1:0] pc_inc;

    assign dist_ext = AW'(jump_distance_i);
    assign pc_inc   = pc_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
            end
            S_FETCH: begin
                if (mem_ack_i) begin
                    instr_d = mem_data_i;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ex_stall_i) begin
                    // Default exit is the next fetch; halt overrides below.
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    if (rst_req_i) begin
                        pc_d = RESET_VEC;
                    end else if (hlt_i) begin
                        pc_d     = pc_inc;
                        req_d    = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (jump_up_i && jump_down_i) begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end else if (jump_up_i) begin
                        pc_d = pc_q + dist_ext;
                    end else if (jump_down_i) begin
                        pc_d = pc_q - dist_ext;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALT: begin
                if (run_i) begin
                    halted_d = 1'b0;
                    req_d    = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VEC;
            instr_q  <= 8'h00;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign mem_req_o     = req_q;
    assign mem_addr_o    = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_kt8_pc_sequencer.sv
// tb/tb_kt8_pc_sequencer.sv - directed scoreboard bench for kt8_pc_sequencer
// Expected fetch addresses are pushed when an instruction is executed and popped on each request.
module tb_kt8_pc_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       mem_req_o;
    logic [7:0] mem_addr_o;
    logic       mem_ack_i = 1'b0;
    logic [7:0] mem_data_i = 8'h00;
    logic [7:0] instr_o;
    logic       instr_valid_o;
    logic       jump_up_i = 1'b0;
    logic       jump_down_i = 1'b0;
    logic [3:0] jump_distance_i = 4'h0;
    logic       rst_req_i = 1'b0;
    logic       hlt_i = 1'b0;
    logic       ex_stall_i = 1'b0;
    logic       run_i = 1'b0;
    logic [7:0] pc_o;
    logic       halted_o;
    logic       err_o;

    kt8_pc_sequencer #(.AW(8), .RESET_VEC(8'h00)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
        .instr_o         (instr_o),
        .instr_valid_o   (instr_valid_o),
        .jump_up_i       (jump_up_i),
        .jump_down_i     (jump_down_i),
        .jump_distance_i (jump_distance_i),
        .rst_req_i       (rst_req_i),
        .hlt_i           (hlt_i),
        .ex_stall_i      (ex_stall_i),
        .run_i           (run_i),
        .pc_o            (pc_o),
        .halted_o        (halted_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_pc    = 8'h00;
    logic       m_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input int waits);
        int         guard;
        logic [7:0] exp_addr;
        logic [7:0] data;
        guard = 0;
        while (mem_req_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("req_seen", {31'd0, mem_req_o}, 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 32'd1);
            exp_addr = m_pc;
        end else begin
            exp_addr = exp_q.pop_front();
        end
        check("fetch_addr", {24'd0, mem_addr_o}, {24'd0, exp_addr});
        check("valid_in_fetch", {31'd0, instr_valid_o}, 32'd0);
        for (int w = 0; w < waits; w++) begin
            tick();
            check("wait_req", {31'd0, mem_req_o}, 32'd1);
            check("wait_addr", {24'd0, mem_addr_o}, {24'd0, exp_addr});
        end
        data       = 8'($urandom);
        mem_ack_i  = 1'b1;
        mem_data_i = data;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = ~data;
        check("instr", {24'd0, instr_o}, {24'd0, data});
        check("valid_exec", {31'd0, instr_valid_o}, 32'd1);
        check("req_drop", {31'd0, mem_req_o}, 32'd0);
    endtask

    task automatic exec(input logic up, input logic dn, input logic [3:0] d,
                        input logic rr, input logic hl, input int stall);
        logic halt;
        jump_up_i       = up;
        jump_down_i     = dn;
        jump_distance_i = d;
        rst_req_i       = rr;
        hlt_i           = hl;
        ex_stall_i      = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_pc", {24'd0, pc_o}, {24'd0, m_pc});
            check("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            check("stall_err", {31'd0, err_o}, {31'd0, m_err});
        end
        ex_stall_i = 1'b0;
        halt = 1'b0;
        if (rr) m_pc = 8'h00;
        else if (hl) begin m_pc = m_pc + 8'd1; halt = 1'b1; end
        else if (up && dn) begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
        else if (up) m_pc = m_pc + {4'd0, d};
        else if (dn) m_pc = m_pc - {4'd0, d};
        else m_pc = m_pc + 8'd1;
        tick();
        jump_up_i = 1'b0; jump_down_i = 1'b0; jump_distance_i = 4'h0;
        rst_req_i = 1'b0; hlt_i = 1'b0;
        check("exec_pc", {24'd0, pc_o}, {24'd0, m_pc});
        check("exec_valid", {31'd0, instr_valid_o}, 32'd0);
        check("exec_req", {31'd0, mem_req_o}, {31'd0, !halt});
        check("exec_halted", {31'd0, halted_o}, {31'd0, halt});
        check("exec_err", {31'd0, err_o}, {31'd0, m_err});
        if (!halt) exp_q.push_back(m_pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, {24'd0, pc_o}, 32'h00);
        check({tag, "_instr"}, {24'd0, instr_o}, 32'h00);
        check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n_i = 1'b1;
        check("idle_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        check("first_req", {31'd0, mem_req_o}, 32'd1);
        exp_q.push_back(8'h00);

        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); check("seq_pc2", {24'd0, pc_o}, 32'h02);
        exec(1, 0, 4'd14, 0, 0, 0);
        fetch(0); check("at_10", {24'd0, pc_o}, 32'h10);
        exec(1, 0, 4'd5, 0, 0, 0);
        fetch(0); check("fwd_jump", {24'd0, pc_o}, 32'h15);

        exec(0, 1, 4'd7, 1, 0, 2);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); exec(0, 1, 4'd4, 0, 0, 0);
        fetch(0); check("back_wrap", {24'd0, pc_o}, 32'hFE);
        exec(0, 0, 0, 0, 0, 0);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); check("inc_wrap", {24'd0, pc_o}, 32'h00);

        exec(1, 0, 4'd0, 0, 0, 0);
        fetch(3); check("zero_dist", {24'd0, pc_o}, 32'h00);

        exec(1, 0, 4'd15, 0, 0, 0);
        fetch(0); exec(1, 0, 4'd15, 0, 0, 0);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); check("at_20", {24'd0, pc_o}, 32'h20);
        exec(0, 0, 0, 0, 1, 0);
        check("halt_pc", {24'd0, pc_o}, 32'h21);

        rst_req_i = 1'b1; jump_up_i = 1'b1; jump_distance_i = 4'd3; mem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold_pc", {24'd0, pc_o}, 32'h21);
            check("halt_no_req", {31'd0, mem_req_o}, 32'd0);
            check("halt_flag", {31'd0, halted_o}, 32'd1);
        end
        rst_req_i = 1'b0; jump_up_i = 1'b0; jump_distance_i = 4'd0; mem_ack_i = 1'b0;
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        check("resume_halted", {31'd0, halted_o}, 32'd0);
        check("resume_req", {31'd0, mem_req_o}, 32'd1);
        exp_q.push_back(8'h21);
        fetch(0); check("resume_addr", {24'd0, pc_o}, 32'h21);

        exec(1, 0, 4'd15, 0, 0, 0);
        fetch(0); check("at_30", {24'd0, pc_o}, 32'h30);
        exec(1, 1, 4'd7, 0, 0, 0);
        check("err_set", {31'd0, err_o}, 32'd1);
        fetch(0); check("err_next", {24'd0, pc_o}, 32'h31);
        exec(1, 0, 4'd15, 0, 0, 0);
        fetch(0); check("at_40", {24'd0, pc_o}, 32'h40);
        exec(0, 0, 0, 1, 1, 0);
        check("prio_halted", {31'd0, halted_o}, 32'd0);
        fetch(0); check("err_sticky", {31'd0, err_o}, 32'd1);
        exec(0, 0, 0, 0, 0, 0);

        check("pre_reset_req", {31'd0, mem_req_o}, 32'd1);
        rst_n_i = 1'b0;
        tick();
        check_reset_outputs("midfetch");
        rst_n_i = 1'b1;
        m_pc = 8'h00; m_err = 1'b0;
        exp_q.delete();
        tick();
        check("rerun_req", {31'd0, mem_req_o}, 32'd1);
        exp_q.push_back(8'h00);
        fetch(0); exec(0, 0, 0, 0, 0, 0);
        fetch(0); check("rerun_pc", {24'd0, pc_o}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
